ifu: RTL

IFU -- requirements
Module: ifu

---
 rtl/ifu_if.sv | 30 +++
 rtl/ifu.sv | 122 ++++++++++++
 2 files changed

// File: rtl/ifu_if.sv
// Fetch-unit bus bundle: memory request/response, decode output and redirect.
// The master modport is the IFU side; the slave modport is the memory/decode side.
interface ifu_if #(
   parameter int XLEN   = 64,
   parameter int INST_W = 32
);
   logic              mem_req_valid;
   logic              mem_req_ready;
   logic [XLEN-1:0]   mem_req_addr;
   logic              mem_resp_valid;
   logic [INST_W-1:0] mem_resp_data;
   logic              out_valid;
   logic              out_ready;
   logic [INST_W-1:0] out_inst;
   logic [XLEN-1:0]   out_pc;
   logic              redirect_valid;
   logic [XLEN-1:0]   redirect_pc;
   logic              misalign;
   logic [XLEN-1:0]   fetch_cnt;

   modport master (
      output mem_req_valid, mem_req_addr, out_valid, out_inst, out_pc, misalign, fetch_cnt,
      input  mem_req_ready, mem_resp_valid, mem_resp_data, out_ready, redirect_valid, redirect_pc
   );

   modport slave (
      input  mem_req_valid, mem_req_addr, out_valid, out_inst, out_pc, misalign, fetch_cnt,
      output mem_req_ready, mem_resp_valid, mem_resp_data, out_ready, redirect_valid, redirect_pc
   );
endinterface

// File: rtl/ifu.sv
// Single-outstanding instruction fetch unit with redirect squashing.
// Define IFU_MISALIGN_CHK_EN to trap misaligned redirects in a sticky FAULT state.
module ifu #(
   parameter int              XLEN     = 64,
   parameter int              INST_W   = 32,
   parameter logic [XLEN-1:0] RESET_PC = XLEN'(64'h0000_0000_8000_0000)
) (
   input logic   clk,
   input logic   rst,
   ifu_if.master bus
);
   localparam logic [XLEN-1:0] STEP = XLEN'(INST_W / 8);

   typedef enum logic [2:0] {
      S_IDLE,
      S_REQ,
      S_WAIT,
      S_OUT,
      S_DROP
`ifdef IFU_MISALIGN_CHK_EN
      , S_FAULT
`endif
   } state_t;

   state_t            state_q, state_d;
   logic [XLEN-1:0]   pc_q, pc_d;
   logic [XLEN-1:0]   out_pc_q, out_pc_d;
   logic [INST_W-1:0] inst_q, inst_d;
   logic [XLEN-1:0]   cnt_q, cnt_d;

   logic              redir_take;
   logic [XLEN-1:0]   redir_pc;

   // Redirects only land once fetching has started and fetch has not been halted.
   assign redir_take = bus.redirect_valid &&
                       (state_q inside {S_REQ, S_WAIT, S_OUT, S_DROP});

`ifdef IFU_MISALIGN_CHK_EN
   logic redir_bad;
   assign redir_pc  = bus.redirect_pc;
   assign redir_bad = redir_take && (bus.redirect_pc[1:0] != 2'b00);
`else
   assign redir_pc  = {bus.redirect_pc[XLEN-1:2], 2'b00};
`endif

   // NOTE: every signal gets a default before the case, otherwise missed branches infer latches.
   always_comb begin
      state_d  = state_q;
      pc_d     = pc_q;
      out_pc_d = out_pc_q;
      inst_d   = inst_q;
      cnt_d    = cnt_q;

      case (state_q)
         S_IDLE: state_d = S_REQ;
         S_REQ: begin
            if (bus.mem_req_ready) state_d = redir_take ? S_DROP : S_WAIT;
         end
         S_WAIT: begin
            if (redir_take) begin
               // A response arriving alongside the redirect is for the old path.
               state_d = bus.mem_resp_valid ? S_REQ : S_DROP;
            end else if (bus.mem_resp_valid) begin
               inst_d   = bus.mem_resp_data;
               out_pc_d = pc_q;
               state_d  = S_OUT;
            end
         end
         S_OUT: begin
            if (bus.out_ready) begin
               cnt_d   = cnt_q + XLEN'(1);
               pc_d    = pc_q + STEP;
               state_d = S_REQ;
            end
            if (redir_take) state_d = S_REQ;
         end
         S_DROP: begin
            if (bus.mem_resp_valid) state_d = S_REQ;
         end
`ifdef IFU_MISALIGN_CHK_EN
         S_FAULT: state_d = S_FAULT;
`endif
         default: state_d = S_IDLE;
      endcase

      // A redirect always wins over the sequential pc+step update.
      if (redir_take) pc_d = redir_pc;
`ifdef IFU_MISALIGN_CHK_EN
      if (redir_bad) state_d = S_FAULT;
`endif
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= S_IDLE;
         pc_q     <= RESET_PC;
         out_pc_q <= '0;
         inst_q   <= '0;
         cnt_q    <= '0;
      end else begin
         state_q  <= state_d;
         pc_q     <= pc_d;
         out_pc_q <= out_pc_d;
         inst_q   <= inst_d;
         cnt_q    <= cnt_d;
      end
   end

   // Outputs are decoded from registers only, so reset forces them within the same cycle.
   assign bus.mem_req_valid = (state_q == S_REQ);
   assign bus.mem_req_addr  = pc_q;
   assign bus.out_valid     = (state_q == S_OUT);
   assign bus.out_inst      = inst_q;
   assign bus.out_pc        = out_pc_q;
   assign bus.fetch_cnt     = cnt_q;
`ifdef IFU_MISALIGN_CHK_EN
   assign bus.misalign      = (state_q == S_FAULT);
`else
   assign bus.misalign      = 1'b0;
`endif
endmodule
